iwdg_multi: RTL and testbench
=============================

// Module: iwdg_multi
// PURPOSE
//  Parametrised successor of the independent watchdog: NUM_CH independent watchdog channels behind
//  one Wishbone-style slave port, single clock domain. Adds window mode (early refresh = fault),
//  an early-warning interrupt, sticky reset-cause flags and a live counter readback.
//  Sits on the system bus; wdg_rst[ch] drives the reset controller, irq goes to the interrupt controller.
// PARAMETERS
//  NUM_CH     2             number of watchdog channels (1..8)
//  DAT_SIZE   16            bus data width
//  RLR_SIZE   12            reload/window/early-warning/counter width
//  PR_SIZE    3             prescaler select width; divide = 2^(PR+2), 4..512
//  BASE_ADR   32'h0100_0000 base address of channel 0
//  CH_STRIDE  32'h0000_0020 address stride between channels
//  RST_PULSE  4             wdg_rst pulse length in clk cycles (>=1)
// PORTS
//  clk       in   1             system clock, all logic on rising edge
//  rst_n     in   1             reset, asynchronous, active-low
//  dat_m2s   in   DAT_SIZE      write data
//  adr_m2s   in   32            byte address
//  cyc_m2s   in   1             bus cycle
//  stb_m2s   in   1             strobe
//  we_m2s    in   1             1 = write, 0 = read
//  dat_s2m   out  DAT_SIZE      read data, valid with ack_s2m
//  ack_s2m   out  1             one-cycle acknowledge
//  wdg_rst   out  NUM_CH        per-channel reset pulse, active-high
//  irq       out  1             OR over channels of EWIF
// BEHAVIOUR
//  Reset: dat_s2m=0, ack_s2m=0, wdg_rst=0, irq=0; per channel KR=0, PR=0, RLR/WINR=all ones, EWR=0,
//   CNT=all ones, prescaler=0, RUN=0, UNLOCK=0, all SR flags 0.
//  Map (offset in channel): 0x00 KR rw, 0x04 PR, 0x08 RLR, 0x0C SR, 0x10 WINR, 0x14 EWR, 0x18 CNT ro.
//  Bus: cyc&stb&!ack samples request; ack_s2m high exactly 1 cycle later, for 1 cycle; write takes effect
//   on sampling edge; read data registered with ack. Unmapped offset/channel: acked, reads 0, writes dropped.
//  Narrow registers: writes take low bits, reads zero-extend.
//  KR: stores last written value (readback). 0xCCCC: RUN=1 (sticky until rst_n), CNT<=RLR, prescaler<=0.
//   0xAAAA: refresh, CNT<=RLR, prescaler<=0; if RUN and CNT>WINR -> window fault. 0x5555: UNLOCK=1.
//   Any other value: UNLOCK=0. Refresh/start also clear UNLOCK.
//  PR/RLR/WINR/EWR writes honoured only while UNLOCK=1; otherwise acked and ignored. New values take
//   effect at the next reload; never retroactively on CNT.
//  SR bits: 0 RUN, 1 UNLOCK (ro), 2 EWIF, 3 WRF (window fault), 4 TORF (timeout); 2..4 write-1-to-clear,
//   no unlock needed.
//  Count: while RUN, prescaler counts 0..2^(PR+2)-1; tick on wrap. On tick: CNT==0 -> timeout fault,
//   else CNT<=CNT-1. If EWR!=0 and CNT-1==EWR on tick -> EWIF=1.
//  Fault (timeout or window): set TORF or WRF, CNT<=RLR, prescaler<=0, wdg_rst[ch] high RST_PULSE cycles;
//   RUN stays 1. Fault during active pulse restarts pulse length.
//  Simultaneous: bus refresh and tick same cycle -> refresh wins, no decrement, no timeout. EWIF set and
//   W1C same cycle -> set wins. Window disabled when WINR=all ones (CNT>WINR impossible).
//  irq = |(EWIF) registered; irq deasserts cycle after last EWIF cleared.
//  rst_n asserted mid-transfer or mid-pulse: everything to reset values immediately; no ack issued.
// STRUCTURE
//  Package wdg_pkg: key constants (KEY_START, KEY_RELOAD, KEY_UNLOCK), register offsets, SR bit indices.
//  Sub-module wdg_channel: one channel's registers, prescaler, counter, fault/pulse logic; top holds
//   address decode, ack/read mux and NUM_CH generate instances.
// TESTING
//  Read ch0 RLR after reset -> dat_s2m=0x0FFF; SR -> 0x0000; irq=0, wdg_rst=0.
//  ch0: 0x5555, RLR=0x002, PR=0, 0xCCCC, no refresh -> wdg_rst[0] high 4 cycles after 12 clk; SR=0x0011.
//  ch1: unlock, RLR=0x010, WINR=0x008, start, refresh at CNT=0x00C -> wdg_rst[1] pulse, SR.WRF=1;
//   refresh at CNT=0x005 -> no fault.
//  ch0: EWR=0x003, RLR=0x008, start -> irq=1 at CNT=0x003; write SR=0x0004 -> irq=0 next cycle.
//  Locked write RLR=0x001 then read RLR -> unchanged; read unmapped 0x0100_0040 -> acked, 0x0000.
//  Refresh issued on tick cycle with CNT=0 -> no fault, CNT=RLR; rst_n low mid-pulse -> wdg_rst=0.

Source files
------------

// File: rtl/wdg_pkg.sv
// Shared constants for the multi-channel watchdog: refresh keys, register map, status bit positions.
package wdg_pkg;

   localparam logic [15:0] KEY_START  = 16'hCCCC;
   localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
   localparam logic [15:0] KEY_UNLOCK = 16'h5555;

   localparam logic [31:0] OFS_KR   = 32'h0000_0000;
   localparam logic [31:0] OFS_PR   = 32'h0000_0004;
   localparam logic [31:0] OFS_RLR  = 32'h0000_0008;
   localparam logic [31:0] OFS_SR   = 32'h0000_000C;
   localparam logic [31:0] OFS_WINR = 32'h0000_0010;
   localparam logic [31:0] OFS_EWR  = 32'h0000_0014;
   localparam logic [31:0] OFS_CNT  = 32'h0000_0018;

   localparam int SR_RUN    = 0;
   localparam int SR_UNLOCK = 1;
   localparam int SR_EWIF   = 2;
   localparam int SR_WRF    = 3;
   localparam int SR_TORF   = 4;
   localparam int SR_W      = 5;

   typedef enum logic [2:0] {
      REG_KR   = 3'd0,
      REG_PR   = 3'd1,
      REG_RLR  = 3'd2,
      REG_SR   = 3'd3,
      REG_WINR = 3'd4,
      REG_EWR  = 3'd5,
      REG_CNT  = 3'd6,
      REG_NONE = 3'd7
   } reg_sel_e;

   // Offsets not listed (including misaligned ones) map to REG_NONE: acked, read 0, write dropped.
   function automatic reg_sel_e decode_ofs(input logic [31:0] ofs);
      reg_sel_e sel;
      case (ofs)
         OFS_KR:   sel = REG_KR;
         OFS_PR:   sel = REG_PR;
         OFS_RLR:  sel = REG_RLR;
         OFS_SR:   sel = REG_SR;
         OFS_WINR: sel = REG_WINR;
         OFS_EWR:  sel = REG_EWR;
         OFS_CNT:  sel = REG_CNT;
         default:  sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/wdg_channel.sv
// One watchdog channel: key/config registers, prescaler, down-counter, window/timeout faults, reset pulse.
// Register writes act on the bus sampling edge; read data is combinational from state; no backpressure.
module wdg_channel
   import wdg_pkg::*;
#(
   parameter int DAT_SIZE  = 16,
   parameter int RLR_SIZE  = 12,
   parameter int PR_SIZE   = 3,
   parameter int RST_PULSE = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                wr_i,
   input  logic [2:0]          sel_i,
   input  logic [DAT_SIZE-1:0] wdat_i,
   output logic [DAT_SIZE-1:0] rdat_o,
   output logic                wdg_rst_o,
   output logic                ewif_o
);

   localparam int PSC_W = (1 << PR_SIZE) + 1;
   localparam int SH_W  = PR_SIZE + 1;
   localparam int PW    = $clog2(RST_PULSE + 1);
   localparam logic [PSC_W-1:0] PSC_ONES = '1;
   localparam logic [SH_W-1:0]  SH_MAX   = SH_W'((1 << PR_SIZE) - 1);

   logic [DAT_SIZE-1:0] kr_q, kr_d;
   logic [PR_SIZE-1:0]  pr_q, pr_d, pr_a_q, pr_a_d;
   logic [RLR_SIZE-1:0] rlr_q, rlr_d, winr_q, winr_d, ewr_q, ewr_d;
   logic [RLR_SIZE-1:0] winr_a_q, winr_a_d, ewr_a_q, ewr_a_d;
   logic [RLR_SIZE-1:0] cnt_q, cnt_d, cnt_dec;
   logic [PSC_W-1:0]    psc_q, psc_d, psc_max;
   logic [PW-1:0]       pulse_q, pulse_d;
   logic                run_q, run_d, unlock_q, unlock_d;
   logic                ewif_q, ewif_d, wrf_q, wrf_d, torf_q, torf_d;
   logic                kr_wr, key_start, key_reload, key_unlock;
   logic                tick, reload, fault;
   logic [SR_W-1:0]     sr;

   assign kr_wr      = wr_i && (sel_i == REG_KR);
   assign key_start  = kr_wr && (wdat_i == DAT_SIZE'(KEY_START));
   assign key_reload = kr_wr && (wdat_i == DAT_SIZE'(KEY_RELOAD));
   assign key_unlock = kr_wr && (wdat_i == DAT_SIZE'(KEY_UNLOCK));

   // Prescaler terminal count 2^(PR+2)-1, built by right-shifting an all-ones word.
   assign psc_max = PSC_ONES >> (SH_MAX - SH_W'(pr_a_q));
   assign tick    = run_q && (psc_q == psc_max);
   assign cnt_dec = cnt_q - 1'b1;

   always_comb begin
      kr_d     = kr_q;
      pr_d     = pr_q;
      rlr_d    = rlr_q;
      winr_d   = winr_q;
      ewr_d    = ewr_q;
      pr_a_d   = pr_a_q;
      winr_a_d = winr_a_q;
      ewr_a_d  = ewr_a_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      unlock_d = unlock_q;
      ewif_d   = ewif_q;
      wrf_d    = wrf_q;
      torf_d   = torf_q;
      reload   = 1'b0;
      fault    = 1'b0;
      psc_d    = run_q ? (tick ? '0 : psc_q + 1'b1) : '0;
      pulse_d  = (pulse_q != '0) ? pulse_q - 1'b1 : '0;

      if (kr_wr) begin
         kr_d     = wdat_i;
         unlock_d = key_unlock;
      end
      if (key_start) begin
         run_d  = 1'b1;
         reload = 1'b1;
      end
      if (key_reload) begin
         reload = 1'b1;
         if (run_q && (cnt_q > winr_a_q)) begin
            fault = 1'b1;
            wrf_d = 1'b1;
         end
      end

      if (wr_i && unlock_q) begin
         case (sel_i)
            REG_PR:   pr_d   = wdat_i[PR_SIZE-1:0];
            REG_RLR:  rlr_d  = wdat_i[RLR_SIZE-1:0];
            REG_WINR: winr_d = wdat_i[RLR_SIZE-1:0];
            REG_EWR:  ewr_d  = wdat_i[RLR_SIZE-1:0];
            default: ;
         endcase
      end

      if (wr_i && (sel_i == REG_SR)) begin
         if (wdat_i[SR_EWIF]) ewif_d = 1'b0;
         if (wdat_i[SR_WRF])  wrf_d  = 1'b0;
         if (wdat_i[SR_TORF]) torf_d = 1'b0;
      end

      // A bus refresh/start on the tick cycle suppresses the decrement and any timeout.
      if (!reload && tick) begin
         if (cnt_q == '0) begin
            fault  = 1'b1;
            torf_d = 1'b1;
         end else begin
            cnt_d = cnt_dec;
            if ((ewr_a_q != '0) && (cnt_dec == ewr_a_q)) ewif_d = 1'b1;
         end
      end

      if (fault) begin
         reload  = 1'b1;
         pulse_d = PW'(RST_PULSE);
      end

      if (reload) begin
         cnt_d    = rlr_q;
         psc_d    = '0;
         pr_a_d   = pr_q;
         winr_a_d = winr_q;
         ewr_a_d  = ewr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         kr_q     <= '0;
         pr_q     <= '0;
         rlr_q    <= '1;
         winr_q   <= '1;
         ewr_q    <= '0;
         pr_a_q   <= '0;
         winr_a_q <= '1;
         ewr_a_q  <= '0;
         cnt_q    <= '1;
         psc_q    <= '0;
         pulse_q  <= '0;
         run_q    <= 1'b0;
         unlock_q <= 1'b0;
         ewif_q   <= 1'b0;
         wrf_q    <= 1'b0;
         torf_q   <= 1'b0;
      end else begin
         kr_q     <= kr_d;
         pr_q     <= pr_d;
         rlr_q    <= rlr_d;
         winr_q   <= winr_d;
         ewr_q    <= ewr_d;
         pr_a_q   <= pr_a_d;
         winr_a_q <= winr_a_d;
         ewr_a_q  <= ewr_a_d;
         cnt_q    <= cnt_d;
         psc_q    <= psc_d;
         pulse_q  <= pulse_d;
         run_q    <= run_d;
         unlock_q <= unlock_d;
         ewif_q   <= ewif_d;
         wrf_q    <= wrf_d;
         torf_q   <= torf_d;
      end
   end

   always_comb begin
      sr            = '0;
      sr[SR_RUN]    = run_q;
      sr[SR_UNLOCK] = unlock_q;
      sr[SR_EWIF]   = ewif_q;
      sr[SR_WRF]    = wrf_q;
      sr[SR_TORF]   = torf_q;
   end

   always_comb begin
      case (sel_i)
         REG_KR:   rdat_o = kr_q;
         REG_PR:   rdat_o = DAT_SIZE'(pr_q);
         REG_RLR:  rdat_o = DAT_SIZE'(rlr_q);
         REG_SR:   rdat_o = DAT_SIZE'(sr);
         REG_WINR: rdat_o = DAT_SIZE'(winr_q);
         REG_EWR:  rdat_o = DAT_SIZE'(ewr_q);
         REG_CNT:  rdat_o = DAT_SIZE'(cnt_q);
         default:  rdat_o = '0;
      endcase
   end

   assign wdg_rst_o = (pulse_q != '0);
   assign ewif_o    = ewif_q;

endmodule

// File: rtl/iwdg_multi.sv
// NUM_CH independent watchdogs behind one Wishbone-style slave; ack and read data one cycle after request,
// never stalled; unmapped accesses are acked with zero data and have no effect.
module iwdg_multi
   import wdg_pkg::*;
#(
   parameter int          NUM_CH    = 2,
   parameter int          DAT_SIZE  = 16,
   parameter int          RLR_SIZE  = 12,
   parameter int          PR_SIZE   = 3,
   parameter logic [31:0] BASE_ADR  = 32'h0100_0000,
   parameter logic [31:0] CH_STRIDE = 32'h0000_0020,
   parameter int          RST_PULSE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DAT_SIZE-1:0] dat_m2s,
   input  logic [31:0]         adr_m2s,
   input  logic                cyc_m2s,
   input  logic                stb_m2s,
   input  logic                we_m2s,
   output logic [DAT_SIZE-1:0] dat_s2m,
   output logic                ack_s2m,
   output logic [NUM_CH-1:0]   wdg_rst,
   output logic                irq
);

   logic                req;
   logic                ack_q, ack_d, irq_q, irq_d;
   logic [DAT_SIZE-1:0] dat_q, dat_d, rd_any;
   logic [DAT_SIZE-1:0] ch_rdat [NUM_CH];
   logic [NUM_CH-1:0]   ch_ewif, ch_rst;

   // The pending ack blocks resampling, so a held cyc/stb yields one ack per transfer.
   assign req = cyc_m2s && stb_m2s && !ack_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [31:0] CH_BASE = BASE_ADR + CH_STRIDE * 32'(c);
      logic [31:0] ofs;
      logic        hit;
      logic [2:0]  sel;

      assign ofs = adr_m2s - CH_BASE;
      assign hit = (ofs < CH_STRIDE);
      assign sel = hit ? decode_ofs(ofs) : REG_NONE;

      wdg_channel #(
         .DAT_SIZE (DAT_SIZE),
         .RLR_SIZE (RLR_SIZE),
         .PR_SIZE  (PR_SIZE),
         .RST_PULSE(RST_PULSE)
      ) u_ch (
         .clk_i    (clk),
         .rst_n_i  (rst_n),
         .wr_i     (req && we_m2s),
         .sel_i    (sel),
         .wdat_i   (dat_m2s),
         .rdat_o   (ch_rdat[c]),
         .wdg_rst_o(ch_rst[c]),
         .ewif_o   (ch_ewif[c])
      );
   end

   always_comb begin
      rd_any = '0;
      for (int c = 0; c < NUM_CH; c++) rd_any = rd_any | ch_rdat[c];
   end

   assign ack_d = req;
   assign dat_d = (req && !we_m2s) ? rd_any : '0;
   assign irq_d = |ch_ewif;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         irq_q <= irq_d;
      end
   end

   assign ack_s2m = ack_q;
   assign dat_s2m = dat_q;
   assign irq     = irq_q;
   assign wdg_rst = ch_rst;

endmodule

// File: tb/tb_iwdg_multi.sv
// Directed bench for iwdg_multi: bus access, timeout, window fault, early warning, lock, unmapped, reset.
module tb_iwdg_multi;

   localparam logic [31:0] CH0 = 32'h0100_0000;
   localparam logic [31:0] CH1 = 32'h0100_0020;
   localparam logic [31:0] KR = 32'h00, PR = 32'h04, RLR = 32'h08, SR = 32'h0C;
   localparam logic [31:0] WINR = 32'h10, EWR = 32'h14, CNT = 32'h18;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] dat_m2s, dat_s2m;
   logic [31:0] adr_m2s;
   logic        cyc_m2s, stb_m2s, we_m2s, ack_s2m, irq;
   logic [1:0]  wdg_rst;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   iwdg_multi #(
      .NUM_CH   (2),
      .DAT_SIZE (16),
      .RLR_SIZE (12),
      .PR_SIZE  (3),
      .BASE_ADR (32'h0100_0000),
      .CH_STRIDE(32'h0000_0020),
      .RST_PULSE(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .dat_m2s(dat_m2s),
      .adr_m2s(adr_m2s),
      .cyc_m2s(cyc_m2s),
      .stb_m2s(stb_m2s),
      .we_m2s (we_m2s),
      .dat_s2m(dat_s2m),
      .ack_s2m(ack_s2m),
      .wdg_rst(wdg_rst),
      .irq    (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   // Entered and left #1 after a rising edge.
   task automatic bus(input logic [31:0] a, input logic w, input logic [15:0] d, output logic [15:0] r);
      int n;
      adr_m2s = a;
      we_m2s  = w;
      dat_m2s = d;
      cyc_m2s = 1'b1;
      stb_m2s = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack_s2m && n < 8);
      if (!ack_s2m) chk("bus_ack", 32'(ack_s2m), 32'd1);
      r = dat_s2m;
      cyc_m2s = 1'b0;
      stb_m2s = 1'b0;
      we_m2s  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] d);
      logic [15:0] dummy;
      bus(a, 1'b1, d, dummy);
   endtask

   task automatic rd(input logic [31:0] a, output logic [15:0] r);
      bus(a, 1'b0, 16'h0000, r);
   endtask

   initial begin
      #500000;
      $display("FAIL tb_timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] v;
      logic [16:0] pat;
      int          n;

      rst_n   = 1'b0;
      cyc_m2s = 1'b0;
      stb_m2s = 1'b0;
      we_m2s  = 1'b0;
      adr_m2s = '0;
      dat_m2s = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_wdg_rst", 32'(wdg_rst), 32'd0);
      rd(CH0 + RLR, v);  chk("rst_rlr", 32'(v), 32'h0FFF);
      rd(CH0 + SR, v);   chk("rst_sr", 32'(v), 32'h0000);
      rd(CH0 + CNT, v);  chk("rst_cnt", 32'(v), 32'h0FFF);
      rd(CH1 + WINR, v); chk("rst_winr1", 32'(v), 32'h0FFF);

      // ch0 timeout: RLR=2, divide 4 -> fault on the 12th edge after start, 4-cycle pulse
      wr(CH0 + KR, 16'h5555);
      wr(CH0 + RLR, 16'h0002);
      wr(CH0 + PR, 16'h0000);
      wr(CH0 + KR, 16'hCCCC);
      pat = '0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         pat[i] = wdg_rst[0];
      end
      chk("ch0_timeout_pulse", 32'(pat), 32'h0F000);
      rd(CH0 + SR, v); chk("ch0_sr_torf", 32'(v), 32'h0011);

      // ch1 window: RLR=0x10, WINR=8; refresh at CNT=0xC faults
      wr(CH1 + KR, 16'h5555);
      rd(CH1 + SR, v); chk("ch1_sr_unlock", 32'(v), 32'h0002);
      wr(CH1 + RLR, 16'h0010);
      wr(CH1 + WINR, 16'h0008);
      wr(CH1 + KR, 16'hCCCC);
      repeat (16) @(posedge clk);
      #1;
      wr(CH1 + KR, 16'hAAAA);
      chk("ch1_wrf_pulse", 32'(wdg_rst[1]), 32'd1);
      rd(CH1 + SR, v); chk("ch1_sr_wrf", 32'(v), 32'h0009);
      wr(CH1 + SR, 16'h0008);
      rd(CH1 + SR, v); chk("ch1_sr_w1c", 32'(v), 32'h0001);

      // Refresh inside the window, then a refresh landing exactly on the CNT=0 tick
      n = 0;
      do begin
         rd(CH1 + CNT, v);
         n++;
      end while (v != 16'h0005 && n < 100);
      chk("ch1_cnt_reach5", 32'(v), 32'h0005);
      wr(CH1 + KR, 16'hAAAA);
      repeat (67) @(posedge clk);
      #1;
      wr(CH1 + KR, 16'hAAAA);
      chk("tickref_no_rst", 32'(wdg_rst[1]), 32'd0);
      rd(CH1 + CNT, v); chk("tickref_cnt", 32'(v), 32'h0010);
      rd(CH1 + SR, v);  chk("tickref_sr", 32'(v), 32'h0001);

      // ch0 early warning: EWR=3, RLR=8 -> EWIF on the 20th edge, irq one edge later
      wr(CH0 + KR, 16'h5555);
      wr(CH0 + EWR, 16'h0003);
      wr(CH0 + RLR, 16'h0008);
      wr(CH0 + KR, 16'hCCCC);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!irq && n < 60);
      chk("ew_irq_cycle", 32'(n), 32'd21);
      rd(CH0 + CNT, v); chk("ew_cnt", 32'(v), 32'h0003);
      wr(CH0 + SR, 16'h0004);
      chk("ew_irq_hold", 32'(irq), 32'd1);
      @(posedge clk);
      #1;
      chk("ew_irq_clear", 32'(irq), 32'd0);

      // Lock, readback and unmapped accesses
      wr(CH0 + RLR, 16'h0001);
      rd(CH0 + RLR, v);          chk("locked_rlr", 32'(v), 32'h0008);
      rd(CH0 + KR, v);           chk("kr_readback", 32'(v), 32'h0000_CCCC);
      rd(CH0 + PR, v);           chk("pr_readback", 32'(v), 32'h0000);
      rd(32'h0100_0040, v);      chk("unmapped_ch", 32'(v), 32'h0000);
      rd(CH0 + 32'h1C, v);       chk("unmapped_ofs", 32'(v), 32'h0000);

      // Asynchronous reset in the middle of a pulse and a pending request
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wdg_rst[0] && n < 200);
      chk("pulse_seen", 32'(wdg_rst[0]), 32'd1);
      adr_m2s = CH0 + RLR;
      we_m2s  = 1'b0;
      cyc_m2s = 1'b1;
      stb_m2s = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk("arst_wdg_rst", 32'(wdg_rst), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1;
      chk("arst_no_ack", 32'(ack_s2m), 32'd0);
      cyc_m2s = 1'b0;
      stb_m2s = 1'b0;
      rst_n   = 1'b1;
      @(posedge clk);
      #1;
      rd(CH0 + SR, v);  chk("post_rst_sr", 32'(v), 32'h0000);
      rd(CH0 + CNT, v); chk("post_rst_cnt", 32'(v), 32'h0FFF);
      rd(CH1 + RLR, v); chk("post_rst_rlr1", 32'(v), 32'h0FFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
